hazard_ctrl: RTL

- Parametrised hazard/forwarding controller for the 5-stage pipelined core (IF=0, ID=1, EXE=2, MEM=3, WB=4).
- Tracks in-flight destination registers in a shift-register scoreboard and produces registered forwarding selects for EXE.
- Raises the load-use stall and issues flushes on a taken branch or jump from a configurable resolve stage.
- Counts stall and flush events for performance analysis.

---
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID-stage instruction info and branch resolve in,
// stall/flush/forwarding selects and performance counters out.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W    = 5,
  parameter int FWD_DEPTH     = 2,
  parameter int RESOLVE_STAGE = 3,
  parameter int CNT_W         = 32
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  logic                     enable;
  logic                     id_valid;
  logic [REG_ADDR_W-1:0]    id_rs;
  logic [REG_ADDR_W-1:0]    id_rt;
  logic                     id_uses_rs;
  logic                     id_uses_rt;
  logic                     id_wr_en;
  logic [REG_ADDR_W-1:0]    id_wr_addr;
  logic                     id_is_load;
  logic                     br_taken;
  logic                     stall;
  logic [RESOLVE_STAGE-1:0] flush;
  logic [SEL_W-1:0]         fwd_sel_a;
  logic [SEL_W-1:0]         fwd_sel_b;
  logic [CNT_W-1:0]         stall_cnt;
  logic [CNT_W-1:0]         flush_cnt;

  modport master (
    output enable, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_wr_en, id_wr_addr, id_is_load, br_taken,
    input  stall, flush, fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  enable, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_wr_en, id_wr_addr, id_is_load, br_taken,
    output stall, flush, fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: in-flight destination scoreboard,
// registered EXE forwarding selects, load-use stall, branch flush, counters.
module hazard_fwd_pick #(
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = 2
) (
  input  logic [FWD_DEPTH-1:0] hit,
  input  logic                 used,
  output logic [SEL_W-1:0]     sel
);
  // Scan from farthest to nearest so the nearest producer is assigned last.
  always_comb begin
    sel = '0;
    for (int k = FWD_DEPTH; k >= 1; k--)
      if (used && hit[k-1]) sel = SEL_W'(k);
  end
endmodule

module hazard_ctrl #(
  parameter int REG_ADDR_W    = 5,
  parameter int FWD_DEPTH     = 2,
  parameter int RESOLVE_STAGE = 3,
  parameter int CNT_W         = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  hazard_ctrl_if.slave bus
);
  localparam int SEL_W  = $clog2(FWD_DEPTH + 1);
  localparam int KILL_N = (RESOLVE_STAGE - 1 < FWD_DEPTH) ? RESOLVE_STAGE - 1 : FWD_DEPTH;
  localparam bit LATE_RESOLVE = (RESOLVE_STAGE >= 2);

  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic                  is_load;
  } sb_entry_t;

  sb_entry_t [FWD_DEPTH-1:0] sb, sb_nxt;

  logic [1:0][REG_ADDR_W-1:0] src;
  logic [1:0]                 src_used;
  logic [1:0][FWD_DEPTH-1:0]  hit;
  logic [1:0][SEL_W-1:0]      sel;
  logic [SEL_W-1:0]           fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0]           stall_cnt_q, flush_cnt_q;
  logic                       stall_raw, stall, br_eff, bubble0;

  assign src      = {bus.id_rt, bus.id_rs};
  assign src_used = {bus.id_uses_rt, bus.id_uses_rs};

  for (genvar op = 0; op < 2; op++) begin : g_op
    for (genvar i = 0; i < FWD_DEPTH; i++) begin : g_hit
      assign hit[op][i] = sb[i].valid & sb[i].wr_en &
                          (sb[i].wr_addr == src[op]) & (src[op] != '0);
    end
    hazard_fwd_pick #(.FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_pick (
      .hit  (hit[op]),
      .used (src_used[op]),
      .sel  (sel[op])
    );
  end

  assign stall_raw = bus.id_valid & sb[0].is_load &
                     ((hit[0][0] & src_used[0]) | (hit[1][0] & src_used[1]));

  // Resolving in ID: the stalled branch re-presents itself, so the stall wins.
  always_comb begin
    if (LATE_RESOLVE) begin
      br_eff = bus.br_taken;
      stall  = stall_raw & ~bus.br_taken;
    end else begin
      br_eff = bus.br_taken & ~stall_raw;
      stall  = stall_raw;
    end
  end

  assign bubble0 = stall | (br_eff & LATE_RESOLVE) | ~bus.id_valid;

  always_comb begin
    sb_nxt = sb;
    for (int i = 1; i < FWD_DEPTH; i++) sb_nxt[i] = sb[i-1];
    if (bubble0) sb_nxt[0] = '0;
    else         sb_nxt[0] = {1'b1, bus.id_wr_en, bus.id_wr_addr, bus.id_is_load};
    if (br_eff)
      for (int i = 0; i < KILL_N; i++) sb_nxt[i] = '0;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sb          <= '0;
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (bus.enable) begin
      sb      <= sb_nxt;
      fwd_a_q <= bubble0 ? '0 : sel[0];
      fwd_b_q <= bubble0 ? '0 : sel[1];
      if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (br_eff && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.stall     = stall;
  assign bus.flush     = {RESOLVE_STAGE{br_eff}};
  assign bus.fwd_sel_a = fwd_a_q;
  assign bus.fwd_sel_b = fwd_b_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
endmodule
